pio_cfg_loader: RTL

//   Byte-stream front end for the pio configuration bus. It sits directly upstream of pio and

---
 rtl/pio_cfg_loader_if.sv | 26 ++
 rtl/pio_cfg_loader.sv | 125 ++++++++++++
 2 files changed

// File: rtl/pio_cfg_loader_if.sv
// Host byte-stream and pio configuration-bus signals for pio_cfg_loader.
// slave is the loader's view; master is the host/pio side that drives it.
interface pio_cfg_loader_if;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic [3:0]  action;
  logic [4:0]  index;
  logic [1:0]  mindex;
  logic [31:0] din;
  logic [31:0] dout;
  logic        busy;

  modport slave (
    input  s_data, s_valid, m_ready, dout,
    output s_ready, m_data, m_valid, action, index, mindex, din, busy
  );

  modport master (
    output s_data, s_valid, m_ready, dout,
    input  s_ready, m_data, m_valid, action, index, mindex, din, busy
  );
endinterface

// File: rtl/pio_cfg_loader.sv
// Assembles 6-byte host frames into pio config writes held for HOLD_CYCLES,
// then optionally returns the sampled pio dout word as 4 bytes, LSB first.
module pio_cfg_loader #(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned GAP_CYCLES  = 1
) (
  input  logic              clk,
  input  logic              reset,
  pio_cfg_loader_if.slave   bus
);

  typedef enum logic [2:0] {HDR, IDX, DAT, ISSUE, GAP, RESP} state_t;

  localparam int unsigned TMR_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int          TW      = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);

  state_t        state, state_nx;
  logic [7:0]    hdr;
  logic [4:0]    idx_buf;
  logic [23:0]   din_lo;
  logic [1:0]    byte_cnt;
  logic [1:0]    resp_cnt;
  logic [TW-1:0] tmr;
  logic [31:0]   rd_word;
  logic [3:0]    action_q;
  logic [4:0]    index_q;
  logic [1:0]    mindex_q;
  logic [31:0]   din_q;

  logic s_fire, hold_done, gap_done;

  assign s_fire    = bus.s_valid && bus.s_ready;
  assign hold_done = (tmr == HOLD_LAST);
  assign gap_done  = (tmr == GAP_LAST);

  // s_ready is gated by reset so the host sees no acceptance while reset is held.
  assign bus.s_ready = reset && (state == HDR || state == IDX || state == DAT);
  assign bus.busy    = (state != HDR);
  assign bus.m_valid = (state == RESP);
  assign bus.m_data  = (state == RESP) ? rd_word[{resp_cnt, 3'b000} +: 8] : 8'h00;
  assign bus.action  = action_q;
  assign bus.index   = index_q;
  assign bus.mindex  = mindex_q;
  assign bus.din     = din_q;

  always_ff @(posedge clk) begin
    if (!reset) state <= HDR;
    else        state <= state_nx;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nx and no latch is inferred.
    state_nx = state;
    case (state)
      HDR:   if (s_fire) state_nx = IDX;
      IDX:   if (s_fire) state_nx = DAT;
      DAT:   if (s_fire && byte_cnt == 2'd3) state_nx = ISSUE;
      ISSUE: if (hold_done) state_nx = GAP;
      GAP:   if (gap_done) state_nx = hdr[4] ? RESP : HDR;
      RESP:  if (bus.m_ready && resp_cnt == 2'd3) state_nx = HDR;
      default: state_nx = HDR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: frame staging is cleared too, so a frame cut by reset can never
      // leak fields into the next write.
      hdr      <= '0;
      idx_buf  <= '0;
      din_lo   <= '0;
      byte_cnt <= '0;
      resp_cnt <= '0;
      tmr      <= '0;
      rd_word  <= '0;
      action_q <= '0;
      index_q  <= '0;
      mindex_q <= '0;
      din_q    <= '0;
    end else begin
      case (state)
        HDR: begin
          byte_cnt <= '0;
          if (s_fire) hdr <= bus.s_data;
        end
        IDX: if (s_fire) idx_buf <= bus.s_data[4:0];
        DAT: if (s_fire) begin
          byte_cnt <= byte_cnt + 2'd1;
          case (byte_cnt)
            2'd0: din_lo[7:0]   <= bus.s_data;
            2'd1: din_lo[15:8]  <= bus.s_data;
            2'd2: din_lo[23:16] <= bus.s_data;
            default: begin
              // Outputs load only here, on entry to ISSUE.
              action_q <= hdr[3:0];
              mindex_q <= hdr[7:6];
              index_q  <= idx_buf;
              din_q    <= {bus.s_data, din_lo};
              tmr      <= '0;
            end
          endcase
        end
        ISSUE: begin
          tmr <= tmr + 1'b1;
          if (hold_done) begin
            rd_word  <= bus.dout;
            action_q <= '0;
            tmr      <= '0;
          end
        end
        GAP: begin
          tmr      <= tmr + 1'b1;
          resp_cnt <= '0;
        end
        RESP: if (bus.m_ready) resp_cnt <= resp_cnt + 2'd1;
        default: ;
      endcase
    end
  end

endmodule
